// File: rtl/amw_burst_gen.sv
// Linear write command -> AXI INCR bursts (<= BL beats, never crossing 4 KB), with B collection.
// Latency: AW one cycle after entering AW state; W data is a zero-latency pass-through.
// Backpressure: cmd_ready only in IDLE, s_wready follows usr_wready in W, AW stalls at MAX_OST.
// Optional: define AMW_STAT_EN for per-command burst/cycle statistics.
module amw_burst_gen #(
  parameter int AXI_DW    = 128,
  parameter int AXI_AW    = 32,
  parameter int AXI_IW    = 8,
  parameter int AXI_LW    = 8,
  parameter int BL        = 16,
  parameter int LENW      = 24,
  parameter int MAX_OST   = 4,
  parameter int AXI_BYTES = AXI_DW / 8,
  parameter int L         = $clog2(AXI_BYTES)
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic [AXI_AW-1:0]    cmd_addr,
  input  logic [LENW-1:0]      cmd_bytes,
  input  logic [AXI_IW-1:0]    cmd_id,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [AXI_DW-1:0]    s_wdata,
  input  logic                 s_wvalid,
  output logic                 s_wready,
  output logic [AXI_IW-1:0]    usr_awid,
  output logic [AXI_AW-1:0]    usr_awaddr,
  output logic [AXI_LW-1:0]    usr_awlen,
  output logic [2:0]           usr_awsize,
  output logic [1:0]           usr_awburst,
  output logic                 usr_awvalid,
  input  logic                 usr_awready,
  output logic [AXI_DW-1:0]    usr_wdata,
  output logic [AXI_BYTES-1:0] usr_wstrb,
  output logic                 usr_wlast,
  output logic                 usr_wvalid,
  input  logic                 usr_wready,
  input  logic [AXI_IW-1:0]    usr_bid,
  input  logic [1:0]           usr_bresp,
  input  logic                 usr_bvalid,
  output logic                 usr_bready,
  output logic                 done,
  output logic                 done_err,
  output logic [15:0]          stat_bursts,
  output logic [31:0]          stat_cycles
);

  localparam int OW  = $clog2(MAX_OST + 1);
  localparam int CW0 = (LENW > 13) ? LENW : 13;
  localparam int CW  = (CW0 > AXI_LW + 1) ? CW0 : AXI_LW + 1;

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_DRAIN} state_t;

  state_t               state, state_nxt;
  logic [AXI_AW-1:0]    addr;
  logic [AXI_IW-1:0]    id_q;
  logic [LENW-1:0]      rem_beats;
  logic [AXI_BYTES-1:0] last_strb;
  logic [AXI_LW:0]      blen_q;
  logic [AXI_LW:0]      beat_cc;
  logic [OW-1:0]        ost;
  logic                 err, err_nxt;
  logic                 aw_vld_q;
  logic [AXI_AW-1:0]    awaddr_q;
  logic [AXI_LW-1:0]    awlen_q;
  logic                 done_q, done_err_q;

  logic                 cmd_hs, aw_load, aw_hs, w_hs, b_dec, burst_end, drain_exit;
  logic                 w_last_c;
  logic [LENW:0]        bytes_rnd;
  logic [LENW-1:0]      rem_init;
  logic [AXI_BYTES-1:0] strb_init;
  logic [12:0]          to_4k;
  logic [CW-1:0]        blen_min;
  logic [AXI_LW:0]      blen_c;
  logic                 unused_bid;

  // Command decode: round byte count up to beats, build the strobe of the final beat
  always_comb begin
    bytes_rnd = {1'b0, cmd_bytes} + (LENW + 1)'(AXI_BYTES - 1);
    rem_init  = LENW'(bytes_rnd >> L);
    strb_init = '0;
    for (int i = 0; i < AXI_BYTES; i++) begin
      strb_init[i] = (cmd_bytes[L-1:0] == '0) || (i < int'(cmd_bytes[L-1:0]));
    end
  end

  // Next burst length: smallest of remaining beats, BL and beats left in this 4 KB page
  always_comb begin
    to_4k    = (13'd4096 - {1'b0, addr[11:0]}) >> L;
    blen_min = CW'(rem_beats);
    if (CW'(BL) < blen_min)    blen_min = CW'(BL);
    if (CW'(to_4k) < blen_min) blen_min = CW'(to_4k);
    blen_c   = (AXI_LW + 1)'(blen_min);
  end

  assign cmd_hs     = (state == S_IDLE) && cmd_valid;
  assign aw_load    = (state == S_AW) && !aw_vld_q && (ost < OW'(MAX_OST));
  assign aw_hs      = aw_vld_q && usr_awready;
  assign w_hs       = (state == S_W) && s_wvalid && usr_wready;
  assign w_last_c   = (beat_cc == blen_q - (AXI_LW + 1)'(1));
  assign burst_end  = w_hs && w_last_c;
  assign b_dec      = usr_bvalid && (ost != '0);
  assign drain_exit = (state == S_DRAIN) && (ost == '0);

  // Sticky error: cleared on command accept, set by any non-OKAY response
  always_comb begin
    err_nxt = err;
    if (cmd_hs) begin
      err_nxt = 1'b0;
    end else if (usr_bvalid && (usr_bresp != 2'b00)) begin
      err_nxt = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // FSM next state and the combinational W-channel / handshake outputs
  always_comb begin
    state_nxt  = state;
    cmd_ready  = 1'b0;
    s_wready   = 1'b0;
    usr_wvalid = 1'b0;
    usr_wlast  = 1'b0;
    usr_wstrb  = '1;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = S_AW;
      end
      S_AW: begin
        if (aw_hs) state_nxt = S_W;
      end
      S_W: begin
        s_wready   = usr_wready;
        usr_wvalid = s_wvalid;
        usr_wlast  = w_last_c;
        if (w_last_c && (rem_beats == '0)) usr_wstrb = last_strb;
        if (burst_end) state_nxt = (rem_beats != '0) ? S_AW : S_DRAIN;
      end
      S_DRAIN: begin
        if (ost == '0) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Command/burst bookkeeping and the registered AW request
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      addr      <= '0;
      id_q      <= '0;
      rem_beats <= '0;
      last_strb <= '0;
      blen_q    <= '0;
      beat_cc   <= '0;
      aw_vld_q  <= 1'b0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
    end else begin
      if (cmd_hs) begin
        addr      <= cmd_addr & ~AXI_AW'(AXI_BYTES - 1);
        id_q      <= cmd_id;
        rem_beats <= rem_init;
        last_strb <= strb_init;
      end
      if (aw_load) begin
        aw_vld_q <= 1'b1;
        awaddr_q <= addr;
        awlen_q  <= AXI_LW'(blen_c - (AXI_LW + 1)'(1));
        blen_q   <= blen_c;
      end
      if (aw_hs) begin
        aw_vld_q  <= 1'b0;
        addr      <= addr + (AXI_AW'(blen_q) << L);
        rem_beats <= rem_beats - LENW'(blen_q);
        beat_cc   <= '0;
      end
      if (w_hs) begin
        beat_cc <= beat_cc + (AXI_LW + 1)'(1);
      end
    end
  end

  // Outstanding-burst counter: up on AW, down on B; ignores B when nothing is tracked
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ost <= '0;
    end else begin
      case ({aw_hs, b_dec})
        2'b10:   ost <= ost + OW'(1);
        2'b01:   ost <= ost - OW'(1);
        default: ost <= ost;
      endcase
    end
  end

  // Error flag and the one-cycle completion pulse
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      err        <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      err    <= err_nxt;
      done_q <= drain_exit;
      if (drain_exit) done_err_q <= err_nxt;
      else            done_err_q <= 1'b0;
    end
  end

  assign usr_awvalid = aw_vld_q;
  assign usr_awaddr  = awaddr_q;
  assign usr_awlen   = awlen_q;
  assign usr_awid    = id_q;
  assign usr_awsize  = 3'(L);
  assign usr_awburst = 2'b01;
  assign usr_wdata   = s_wdata;
  assign usr_bready  = 1'b1;
  assign done        = done_q;
  assign done_err    = done_err_q;
  assign unused_bid  = ^usr_bid;

`ifdef AMW_STAT_EN
  logic [15:0] burst_cnt, stat_bursts_q;
  logic [31:0] cyc_cnt, stat_cycles_q;

  // Per-command statistics, saturating, published on completion
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      burst_cnt     <= '0;
      cyc_cnt       <= '0;
      stat_bursts_q <= '0;
      stat_cycles_q <= '0;
    end else begin
      if (cmd_hs) begin
        burst_cnt <= '0;
        cyc_cnt   <= '0;
      end else if (state != S_IDLE) begin
        if (aw_hs && (burst_cnt != '1)) burst_cnt <= burst_cnt + 16'd1;
        if (cyc_cnt != '1)              cyc_cnt   <= cyc_cnt + 32'd1;
      end
      if (drain_exit) begin
        stat_bursts_q <= burst_cnt;
        stat_cycles_q <= (cyc_cnt != '1) ? cyc_cnt + 32'd1 : cyc_cnt;
      end
    end
  end

  assign stat_bursts = stat_bursts_q;
  assign stat_cycles = stat_cycles_q;
`else
  assign stat_bursts = '0;
  assign stat_cycles = '0;
`endif

  a_cmd_bytes_nonzero: assert property (@(posedge ACLK) disable iff (!ARESETn)
    cmd_hs |-> (cmd_bytes != '0));

  a_ost_bound: assert property (@(posedge ACLK) disable iff (!ARESETn)
    ost <= OW'(MAX_OST));

endmodule

// File: tb/tb_amw_burst_gen.sv
// Directed bench for amw_burst_gen: burst splitting, strobes, WLAST, OST limit, errors, reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// B responses follow each observed WLAST unless withheld by the main sequence.
module tb_amw_burst_gen;

  logic         ACLK, ARESETn;
  logic [31:0]  cmd_addr;
  logic [23:0]  cmd_bytes;
  logic [7:0]   cmd_id;
  logic         cmd_valid, cmd_ready;
  logic [127:0] s_wdata;
  logic         s_wvalid, s_wready;
  logic [7:0]   usr_awid;
  logic [31:0]  usr_awaddr;
  logic [7:0]   usr_awlen;
  logic [2:0]   usr_awsize;
  logic [1:0]   usr_awburst;
  logic         usr_awvalid, usr_awready;
  logic [127:0] usr_wdata;
  logic [15:0]  usr_wstrb;
  logic         usr_wlast, usr_wvalid, usr_wready;
  logic [7:0]   usr_bid;
  logic [1:0]   usr_bresp;
  logic         usr_bvalid, usr_bready;
  logic         done, done_err;
  logic [15:0]  stat_bursts;
  logic [31:0]  stat_cycles;

  amw_burst_gen #(.MAX_OST(2)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_addr(cmd_addr), .cmd_bytes(cmd_bytes), .cmd_id(cmd_id),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .usr_awid(usr_awid), .usr_awaddr(usr_awaddr), .usr_awlen(usr_awlen),
    .usr_awsize(usr_awsize), .usr_awburst(usr_awburst),
    .usr_awvalid(usr_awvalid), .usr_awready(usr_awready),
    .usr_wdata(usr_wdata), .usr_wstrb(usr_wstrb), .usr_wlast(usr_wlast),
    .usr_wvalid(usr_wvalid), .usr_wready(usr_wready),
    .usr_bid(usr_bid), .usr_bresp(usr_bresp), .usr_bvalid(usr_bvalid),
    .usr_bready(usr_bready),
    .done(done), .done_err(done_err),
    .stat_bursts(stat_bursts), .stat_cycles(stat_cycles)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pat(input int k);
    return {32'hC0DE0000 ^ 32'(k), 32'(k), ~32'(k), 32'(k * 7 + 3)};
  endfunction

  // Shared control set by the main sequence
  logic [7:0] cur_id   = 8'h00;
  bit         src_gap  = 1'b0;
  bit         rdy_gap  = 1'b0;
  bit         b_en     = 1'b1;
  int         b_err_idx = -1;
  int         b_skip   = 0;
  int         src_limit = 0;
  int         src_base = 0;
  int         aw_base = 0, w_base = 0, done_base = 0;

  // Monitor logs
  int           aw_cnt = 0, w_cnt = 0, wl_cnt = 0, done_cnt = 0, aw_attr_bad = 0;
  logic [31:0]  aw_addr_log [0:255];
  logic [7:0]   aw_len_log  [0:255];
  logic [127:0] w_dat_log   [0:2047];
  logic [15:0]  w_strb_log  [0:2047];
  logic         w_last_log  [0:2047];
  logic         last_done_err = 1'b0;
  logic [15:0]  last_stat_bursts = 16'h0;
  logic         src_hs = 1'b0;
  int           src_idx = 0;
  int           b_issued = 0;

  // Falling-edge monitor: every handshake that the next rising edge will complete
  initial begin
    forever begin
      @(negedge ACLK);
      if (ARESETn && usr_awvalid && usr_awready) begin
        if (aw_cnt < 256) begin
          aw_addr_log[aw_cnt] = usr_awaddr;
          aw_len_log[aw_cnt]  = usr_awlen;
        end
        if (usr_awsize !== 3'd4 || usr_awburst !== 2'b01 || usr_awid !== cur_id) aw_attr_bad++;
        aw_cnt++;
      end
      if (ARESETn && usr_wvalid && usr_wready) begin
        if (w_cnt < 2048) begin
          w_dat_log[w_cnt]  = usr_wdata;
          w_strb_log[w_cnt] = usr_wstrb;
          w_last_log[w_cnt] = usr_wlast;
        end
        if (usr_wlast) wl_cnt++;
        w_cnt++;
      end
      src_hs = ARESETn && s_wvalid && s_wready;
      if (done) begin
        done_cnt++;
        last_done_err    = done_err;
        last_stat_bursts = stat_bursts;
      end
    end
  end

  // Payload source: holds an offered beat until accepted, optional random gaps
  initial begin
    s_wvalid = 1'b0;
    s_wdata  = '0;
    forever begin
      @(posedge ACLK);
      #1;
      if (src_hs) src_idx++;
      if (!(s_wvalid && !src_hs) || src_idx >= src_limit)
        s_wvalid = (src_idx < src_limit) && !(src_gap && $urandom_range(0, 2) == 0);
      s_wdata = pat(src_idx);
    end
  end

  // Downstream AW/W readiness
  initial begin
    usr_awready = 1'b1;
    usr_wready  = 1'b1;
    forever begin
      @(posedge ACLK);
      #1;
      usr_awready = !rdy_gap || ($urandom_range(0, 3) != 0);
      usr_wready  = !rdy_gap || ($urandom_range(0, 2) != 0);
    end
  end

  // B responder: one response per completed burst, one per cycle
  initial begin
    usr_bvalid = 1'b0;
    usr_bresp  = 2'b00;
    usr_bid    = 8'h00;
    forever begin
      @(posedge ACLK);
      #1;
      if (b_en && ARESETn && (wl_cnt - b_issued - b_skip) > 0) begin
        usr_bvalid = 1'b1;
        usr_bid    = cur_id;
        usr_bresp  = (b_issued == b_err_idx) ? 2'b10 : 2'b00;
        b_issued++;
      end else begin
        usr_bvalid = 1'b0;
        usr_bresp  = 2'b00;
      end
    end
  end

  task automatic send_cmd(input string tag, input logic [31:0] a, input logic [23:0] nbytes,
                          input logic [7:0] id);
    bit acc = 1'b0;
    cur_id    = id;
    aw_base   = aw_cnt;
    w_base    = w_cnt;
    done_base = done_cnt;
    src_base  = src_limit;
    src_limit = src_limit + (int'(nbytes) + 15) / 16;
    @(posedge ACLK);
    #1;
    cmd_addr  = a;
    cmd_bytes = nbytes;
    cmd_id    = id;
    cmd_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge ACLK);
      if (cmd_ready) begin
        acc = 1'b1;
        break;
      end
    end
    @(posedge ACLK);
    #1;
    cmd_valid = 1'b0;
    check({tag, " cmd accepted"}, acc, 1'b1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && done_cnt == done_base; i++) @(posedge ACLK);
    repeat (3) @(posedge ACLK);
    check({tag, " single done pulse"}, done_cnt - done_base, 1);
  endtask

  task automatic check_w(input string tag, input int n, input int first_len, input int rest_len,
                         input logic [15:0] fin_strb);
    int bad_d = 0, bad_s = 0, bad_l = 0;
    logic exp_last;
    logic [15:0] exp_strb;
    check({tag, " beat count"}, w_cnt - w_base, n);
    for (int i = 0; i < n && (w_base + i) < 2048; i++) begin
      exp_last = (i == n - 1) || ((i + 1 >= first_len) && ((i + 1 - first_len) % rest_len == 0));
      exp_strb = (i == n - 1) ? fin_strb : 16'hFFFF;
      if (w_dat_log[w_base + i] !== pat(src_base + i)) bad_d++;
      if (w_strb_log[w_base + i] !== exp_strb) bad_s++;
      if (w_last_log[w_base + i] !== exp_last) bad_l++;
    end
    check({tag, " data order errors"}, bad_d, 0);
    check({tag, " wstrb errors"}, bad_s, 0);
    check({tag, " wlast errors"}, bad_l, 0);
  endtask

  task automatic check_aw(input string tag, input int idx, input logic [31:0] a, input logic [7:0] len);
    check({tag, " awaddr"}, aw_addr_log[aw_base + idx], a);
    check({tag, " awlen"}, aw_len_log[aw_base + idx], len);
  endtask

  // Global time limit
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time, got no end, expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    bit hit;
    ARESETn   = 1'b0;
    cmd_addr  = '0;
    cmd_bytes = '0;
    cmd_id    = '0;
    cmd_valid = 1'b0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst cmd_ready", cmd_ready, 1'b1);
    check("rst awvalid", usr_awvalid, 1'b0);
    check("rst wvalid", usr_wvalid, 1'b0);
    check("rst s_wready", s_wready, 1'b0);
    check("rst bready", usr_bready, 1'b1);
    check("rst done", {done, done_err}, 2'b00);
    check("rst stats", {stat_bursts, stat_cycles}, 48'h0);
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    repeat (2) @(posedge ACLK);

    // 512 bytes at 0x1000: two full 16-beat bursts
    send_cmd("t1", 32'h0000_1000, 24'd512, 8'h11);
    wait_done("t1", 2000);
    check("t1 aw count", aw_cnt - aw_base, 2);
    check_aw("t1 aw0", 0, 32'h1000, 8'd15);
    check_aw("t1 aw1", 1, 32'h1100, 8'd15);
    check_w("t1", 32, 16, 16, 16'hFFFF);
    check("t1 done_err", last_done_err, 1'b0);
`ifdef AMW_STAT_EN
    check("t1 stat_bursts", last_stat_bursts, 16'd2);
`else
    check("t1 stat_bursts", last_stat_bursts, 16'd0);
`endif

    // 48 bytes at 0x0FF0: split at the 4 KB page
    send_cmd("t2", 32'h0000_0FF0, 24'd48, 8'h22);
    wait_done("t2", 2000);
    check("t2 aw count", aw_cnt - aw_base, 2);
    check_aw("t2 aw0", 0, 32'h0FF0, 8'd0);
    check_aw("t2 aw1", 1, 32'h1000, 8'd1);
    check_w("t2", 3, 1, 16, 16'hFFFF);

    // 20 bytes: partial final strobe
    send_cmd("t3", 32'h0000_2000, 24'd20, 8'h33);
    wait_done("t3", 2000);
    check("t3 aw count", aw_cnt - aw_base, 1);
    check_aw("t3 aw0", 0, 32'h2000, 8'd1);
    check_w("t3", 2, 2, 16, 16'h000F);

    // Unaligned start: low address bits dropped, 1-byte tail
    send_cmd("t3b", 32'h0000_3007, 24'd33, 8'h34);
    wait_done("t3b", 2000);
    check_aw("t3b aw0", 0, 32'h3000, 8'd2);
    check_w("t3b", 3, 3, 16, 16'h0001);

    // 4096 bytes with random gaps on both sides
    src_gap = 1'b1;
    rdy_gap = 1'b1;
    send_cmd("t4", 32'h0000_4000, 24'd4096, 8'h44);
    wait_done("t4", 5000);
    check("t4 aw count", aw_cnt - aw_base, 16);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (aw_addr_log[aw_base + i] !== 32'h4000 + 32'(i * 256) || aw_len_log[aw_base + i] !== 8'd15)
        bad++;
    end
    check("t4 aw sequence errors", bad, 0);
    check_w("t4", 256, 16, 16, 16'hFFFF);
    check("t4 done_err", last_done_err, 1'b0);
    src_gap = 1'b0;
    rdy_gap = 1'b0;

    // OST limit of 2 with B withheld, then one SLVERR
    b_en = 1'b0;
    send_cmd("t5", 32'h0000_8000, 24'd768, 8'h55);
    repeat (150) @(posedge ACLK);
    check("t5 aw while B withheld", aw_cnt - aw_base, 2);
    check("t5 beats while B withheld", w_cnt - w_base, 32);
    check("t5 no done while B withheld", done_cnt - done_base, 0);
    b_err_idx = b_issued;
    b_en = 1'b1;
    wait_done("t5", 2000);
    check("t5 aw count", aw_cnt - aw_base, 3);
    check_w("t5", 48, 16, 16, 16'hFFFF);
    check("t5 done_err", last_done_err, 1'b1);

    // Error flag cleared by the next command
    send_cmd("t5b", 32'h0000_9000, 24'd32, 8'h56);
    wait_done("t5b", 2000);
    check("t5b done_err", last_done_err, 1'b0);

    // Reset in the middle of W
    send_cmd("t6", 32'h0000_A000, 24'd512, 8'h66);
    hit = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge ACLK);
      if (w_cnt - w_base >= 5) begin
        hit = 1'b1;
        break;
      end
    end
    check("t6 reached W", hit, 1'b1);
    #1;
    b_en    = 1'b0;
    ARESETn = 1'b0;
    @(negedge ACLK);
    check("t6 rst awvalid", usr_awvalid, 1'b0);
    check("t6 rst wvalid", usr_wvalid, 1'b0);
    check("t6 rst cmd_ready", cmd_ready, 1'b1);
    check("t6 rst s_wready", s_wready, 1'b0);
    repeat (2) @(posedge ACLK);
    #1;
    b_skip    = wl_cnt - b_issued;
    src_limit = src_idx;
    ARESETn   = 1'b1;
    b_en      = 1'b1;
    repeat (2) @(posedge ACLK);

    send_cmd("t6b", 32'h0000_B000, 24'd64, 8'h67);
    wait_done("t6b", 2000);
    check("t6b aw count", aw_cnt - aw_base, 1);
    check_aw("t6b aw0", 0, 32'hB000, 8'd3);
    check_w("t6b", 4, 4, 16, 16'hFFFF);
    check("t6b done_err", last_done_err, 1'b0);
    check("aw attribute errors", aw_attr_bad, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
